// File: rtl/regfile_writer_pkg.sv
// Shared widths, pending-counter constants and the scoreboard update rule
// for the register-file write front end.
package regfile_writer_pkg;

  localparam int N_REGS     = 32;
  localparam int DATA_W     = 64;
  localparam int WB_DEPTH   = 4;
  localparam int REG_IDX_W  = $clog2(N_REGS);
  localparam int PEND_CNT_W = 2;

  typedef logic [PEND_CNT_W-1:0] pend_cnt_t;

  localparam pend_cnt_t PEND_MAX = pend_cnt_t'(3);

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC,
    PEND_UNDERFLOW
  } pend_op_t;

  // Issue and retire of the same register in one cycle cancel out.
  function automatic pend_op_t pend_op(input logic inc, input logic dec, input pend_cnt_t cnt);
    pend_op_t op;
    op = PEND_HOLD;
    if (inc && !dec) begin
      op = PEND_INC;
    end else if (dec && !inc) begin
      op = (cnt == '0) ? PEND_UNDERFLOW : PEND_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/regfile_writer_wb_fifo.sv
// In-order writeback queue with two ordered write ports and one pop port.
// Latency: an entry pushed at edge k is visible at the head after edge k.
// No internal backpressure: the caller must gate pushes on the exposed count.
module regfile_writer_wb_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  logic [W-1:0]             dat0,
  input  logic                     push1,
  input  logic [W-1:0]             dat1,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt1;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] n_push;

  assign wr_ptr_nxt1 = wr_ptr + PTR_W'(1);
  assign n_push      = CNT_W'(push0) + CNT_W'(push1);

  // Port 1 lands behind port 0 when both push; alone it takes the tail slot.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem[wr_ptr] <= dat0;
    end
    if (push1) begin
      mem[push0 ? wr_ptr_nxt1 : wr_ptr] <= dat1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + n_push - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_writer.sv
// Merges ALU and load writebacks into the register file write port and tracks pending writes.
// Latency: a writeback accepted at edge k into an empty queue is written at edge k+1.
// Backpressure: ready comes from registered occupancy only; ALU wins the last free slot.
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int N     = N_REGS,
  parameter int SIZE  = DATA_W,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [$clog2(N)-1:0]  alu_rd,
  input  logic [SIZE-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [$clog2(N)-1:0]  mem_rd,
  input  logic [SIZE-1:0]       mem_data,
  input  logic                  issue_valid,
  input  logic [$clog2(N)-1:0]  issue_rd,
  output logic                  issue_ready,
  input  logic [$clog2(N)-1:0]  qa,
  input  logic [$clog2(N)-1:0]  qb,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  we,
  output logic [$clog2(N)-1:0]  rw,
  output logic [SIZE-1:0]       din
);

  localparam int IDX_W = $clog2(N);
  localparam int ENT_W = IDX_W + SIZE;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic             alu_push;
  logic             mem_push;
  logic             pop;
  logic             pop_nz;
  logic             issue_inc;
  logic             pop_underflow;
  pend_cnt_t        cnt [N];

  assign alu_ready = (count < CNT_W'(DEPTH));
  assign mem_ready = (count <= CNT_W'(DEPTH - 2)) ||
                     ((count == CNT_W'(DEPTH - 1)) && !alu_valid);

  // Writes to x0 are accepted but never occupy a queue slot.
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);

  regfile_writer_wb_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (alu_push),
    .dat0  ({alu_rd, alu_data}),
    .push1 (mem_push),
    .dat1  ({mem_rd, mem_data}),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign we  = (count != '0);
  assign rw  = head[ENT_W-1:SIZE];
  assign din = head[SIZE-1:0];
  assign pop = we;

  assign pop_nz      = pop && (rw != '0);
  assign issue_ready = (cnt[issue_rd] != PEND_MAX);
  assign issue_inc   = issue_valid && issue_ready && (issue_rd != '0);

  // Entry 0 only ever sees reset, so it stays a constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < N; r++) begin
        case (pend_op(issue_inc && (issue_rd == IDX_W'(r)),
                      pop_nz && (rw == IDX_W'(r)), cnt[r]))
          PEND_INC: cnt[r] <= cnt[r] + pend_cnt_t'(1);
          PEND_DEC: cnt[r] <= cnt[r] - pend_cnt_t'(1);
          default:  cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  assign busy_a = (cnt[qa] != '0);
  assign busy_b = (cnt[qb] != '0);

  assign pop_underflow = pop_nz && (cnt[rw] == '0) &&
                         !(issue_inc && (issue_rd == rw));

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!pop_underflow)
        else $error("regfile_writer: retired write to x%0d with no pending issue", rw);
    end
  end

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: ordering, ready rules, scoreboard and reset.
module tb_regfile_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic        alu_ready, mem_ready, issue_ready;
  logic [4:0]  alu_rd, mem_rd, issue_rd, qa, qb, rw;
  logic [63:0] alu_data, mem_data, din;
  logic        busy_a, busy_b, we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_writer dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .qa          (qa),
    .qb          (qb),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .we          (we),
    .rw          (rw),
    .din         (din)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    alu_rd = '0; mem_rd = '0; issue_rd = '0; qa = '0; qb = '0;
    alu_data = '0; mem_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_we", we, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_busy_a", busy_a, 1'b0);

    // Single ALU writeback, one-cycle latency.
    qa = 5'd5;
    issue(5'd5);
    chk("x5_busy_after_issue", busy_a, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hA;
    tick();
    alu_valid = 1'b0;
    chk("x5_we", we, 1'b1);
    chk("x5_rw", rw, 5'd5);
    chk("x5_din", din, 64'hA);
    tick();
    chk("x5_drained_we", we, 1'b0);
    chk("x5_busy_cleared", busy_a, 1'b0);

    // Same-cycle ALU and MEM: ALU goes first.
    issue(5'd3);
    issue(5'd4);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h1;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h2;
    #1;
    chk("dual_alu_ready", alu_ready, 1'b1);
    chk("dual_mem_ready", mem_ready, 1'b1);
    tick();
    idle();
    chk("dual_first_rw", rw, 5'd3);
    chk("dual_first_din", din, 64'h1);
    tick();
    chk("dual_second_we", we, 1'b1);
    chk("dual_second_rw", rw, 5'd4);
    chk("dual_second_din", din, 64'h2);
    tick();
    chk("dual_drained", we, 1'b0);

    // Build the queue to DEPTH-1 and hit the MEM-yields rule.
    for (int r = 10; r <= 15; r++) issue(5'(r));
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'h10;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 64'h11;
    tick();
    chk("fill_cnt2", dut.count, 3'd2);
    chk("fill_head10", rw, 5'd10);
    alu_rd = 5'd12; alu_data = 64'h12;
    mem_rd = 5'd13; mem_data = 64'h13;
    #1;
    chk("fill_mem_ready_at2", mem_ready, 1'b1);
    tick();
    chk("fill_cnt3", dut.count, 3'd3);
    chk("fill_head11", rw, 5'd11);
    alu_rd = 5'd14; alu_data = 64'h14;
    mem_rd = 5'd15; mem_data = 64'h15;
    #1;
    chk("full1_alu_ready", alu_ready, 1'b1);
    chk("full1_mem_ready", mem_ready, 1'b0);
    tick();
    chk("full1_cnt", dut.count, 3'd3);
    chk("full1_head12", rw, 5'd12);
    alu_valid = 1'b0;
    #1;
    chk("full1_mem_ready_no_alu", mem_ready, 1'b1);
    tick();
    mem_valid = 1'b0;
    chk("after_mem_cnt", dut.count, 3'd3);
    chk("order_13", rw, 5'd13);
    tick();
    chk("order_14", rw, 5'd14);
    chk("order_14_din", din, 64'h14);
    tick();
    chk("order_15", rw, 5'd15);
    chk("order_15_din", din, 64'h15);
    tick();
    chk("fill_drained", we, 1'b0);

    // Saturate x7's pending counter and drain it.
    qa = 5'd7;
    issue(5'd7);
    issue(5'd7);
    issue(5'd7);
    issue_rd = 5'd7;
    #1;
    chk("x7_issue_ready_sat", issue_ready, 1'b0);
    chk("x7_busy", busy_a, 1'b1);
    issue_valid = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h71;
    tick();
    issue_valid = 1'b0;
    chk("x7_w1_busy", busy_a, 1'b1);
    chk("x7_w1_ready_still0", issue_ready, 1'b0);
    alu_data = 64'h72;
    tick();
    chk("x7_w2_busy", busy_a, 1'b1);
    chk("x7_w2_issue_ready", issue_ready, 1'b1);
    alu_data = 64'h73;
    tick();
    alu_valid = 1'b0;
    chk("x7_w3_busy", busy_a, 1'b1);
    chk("x7_w3_din", din, 64'h73);
    tick();
    chk("x7_drained_busy", busy_a, 1'b0);

    // Issue x9 on the same edge a queued x9 retires.
    qa = 5'd9;
    issue(5'd9);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    tick();
    alu_valid = 1'b0;
    chk("x9_head", rw, 5'd9);
    issue(5'd9);
    chk("x9_busy_after_overlap", busy_a, 1'b1);
    chk("x9_queue_empty", we, 1'b0);
    issue(5'd9);
    issue_rd = 5'd9;
    #1;
    chk("x9_cnt_is2_ready", issue_ready, 1'b1);

    // Writebacks and issues to x0 are dropped.
    qa = 5'd0; qb = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hBEEF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    chk("x0_we", we, 1'b0);
    chk("x0_cnt", dut.count, 3'd0);
    chk("x0_busy_a", busy_a, 1'b0);
    chk("x0_busy_b", busy_b, 1'b0);

    // Reset with three entries queued.
    for (int r = 20; r <= 23; r++) issue(5'(r));
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'h20;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 64'h21;
    tick();
    alu_rd = 5'd22; alu_data = 64'h22;
    mem_rd = 5'd23; mem_data = 64'h23;
    tick();
    idle();
    qa = 5'd9; qb = 5'd23;
    chk("pre_rst_cnt", dut.count, 3'd3);
    chk("pre_rst_we", we, 1'b1);
    chk("pre_rst_busy_b", busy_b, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_we", we, 1'b0);
    chk("async_rst_busy_a", busy_a, 1'b0);
    chk("async_rst_busy_b", busy_b, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1'b1);
    chk("post_rst_mem_ready", mem_ready, 1'b1);
    chk("post_rst_issue_ready", issue_ready, 1'b1);
    tick();
    chk("post_rst_we", we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
